// File: rtl/schedule_2nd.sv
// schedule_2nd: second scheduling stage between schedule_1st and execute.
// Reads operands from the register file and forwards same-cycle writeback
// data. Tracks in-flight destination writes with a per-register pending
// counter and requests a hold (STALL) on RAW hazards or counter saturation.
// Ports:
//   CLK, RST (sync, active high), FLUSH, MEM_WAIT    - control
//   SCHEDULE_1ST_*                                  - incoming instruction
//   REG_RS{1,2}_ADDR / _DATA                        - register file read
//   WB_VALID, WB_RD, WB_DATA                        - retiring write
//   STALL                                           - combinational hold
//   SCHEDULE_2ND_*                                  - registered to execute
module schedule_2nd #(
  parameter int PEND_W = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        MEM_WAIT,
  input  logic [31:0] SCHEDULE_1ST_PC,
  input  logic [6:0]  SCHEDULE_1ST_OPCODE,
  input  logic [4:0]  SCHEDULE_1ST_RD,
  input  logic [4:0]  SCHEDULE_1ST_RS1,
  input  logic [4:0]  SCHEDULE_1ST_RS2,
  input  logic [11:0] SCHEDULE_1ST_CSR,
  input  logic [2:0]  SCHEDULE_1ST_FUNCT3,
  input  logic [6:0]  SCHEDULE_1ST_FUNCT7,
  input  logic [31:0] SCHEDULE_1ST_IMM,
  output logic [4:0]  REG_RS1_ADDR,
  input  logic [31:0] REG_RS1_DATA,
  output logic [4:0]  REG_RS2_ADDR,
  input  logic [31:0] REG_RS2_DATA,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_RD,
  input  logic [31:0] WB_DATA,
  output logic        STALL,
  output logic [31:0] SCHEDULE_2ND_PC,
  output logic [6:0]  SCHEDULE_2ND_OPCODE,
  output logic [4:0]  SCHEDULE_2ND_RD,
  output logic [11:0] SCHEDULE_2ND_CSR,
  output logic [2:0]  SCHEDULE_2ND_FUNCT3,
  output logic [6:0]  SCHEDULE_2ND_FUNCT7,
  output logic [31:0] SCHEDULE_2ND_IMM,
  output logic [31:0] SCHEDULE_2ND_RS1_DATA,
  output logic [31:0] SCHEDULE_2ND_RS2_DATA
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [31:0][PEND_W-1:0] pend;
  logic        writes_rd, uses_rs1, uses_rs2;
  logic        wb_hit1, wb_hit2, wb_hitd;
  logic        raw1, raw2, sat, accept;
  logic [31:0] op1, op2;
  logic [31:0] inc_v, dec_v;

  assign REG_RS1_ADDR = SCHEDULE_1ST_RS1;
  assign REG_RS2_ADDR = SCHEDULE_1ST_RS2;

  // register usage decode; opcode 0 (bubble) falls to default
  always_comb begin
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (SCHEDULE_1ST_OPCODE)
      7'b0110111, 7'b0010111, 7'b1101111: writes_rd = 1'b1;
      7'b1100111, 7'b0000011, 7'b0010011: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
      end
      7'b0110011: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      7'b1100011, 7'b0100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b1110011: begin
        writes_rd = (SCHEDULE_1ST_FUNCT3 != 3'd0);
        uses_rs1  = (SCHEDULE_1ST_FUNCT3 == 3'd1) || (SCHEDULE_1ST_FUNCT3 == 3'd2) ||
                    (SCHEDULE_1ST_FUNCT3 == 3'd3);
      end
      default: ;
    endcase
    if (SCHEDULE_1ST_RD == 5'd0) writes_rd = 1'b0;
  end

  assign wb_hit1 = WB_VALID && (WB_RD == SCHEDULE_1ST_RS1);
  assign wb_hit2 = WB_VALID && (WB_RD == SCHEDULE_1ST_RS2);
  assign wb_hitd = WB_VALID && (WB_RD == SCHEDULE_1ST_RD);

  // a retiring write clears the hazard only if it is the last one in flight
  assign raw1 = uses_rs1 && (pend[SCHEDULE_1ST_RS1] != '0) &&
                !(wb_hit1 && pend[SCHEDULE_1ST_RS1] == PEND_ONE);
  assign raw2 = uses_rs2 && (pend[SCHEDULE_1ST_RS2] != '0) &&
                !(wb_hit2 && pend[SCHEDULE_1ST_RS2] == PEND_ONE);
  // a same-cycle retire to rd frees a slot, so the new write fits
  assign sat  = writes_rd && (pend[SCHEDULE_1ST_RD] == PEND_MAX) && !wb_hitd;

  assign STALL  = (raw1 || raw2 || sat) && !FLUSH && !RST;
  assign accept = !RST && !FLUSH && !MEM_WAIT && !STALL;

  assign op1 = (SCHEDULE_1ST_RS1 == 5'd0) ? 32'd0 : (wb_hit1 ? WB_DATA : REG_RS1_DATA);
  assign op2 = (SCHEDULE_1ST_RS2 == 5'd0) ? 32'd0 : (wb_hit2 ? WB_DATA : REG_RS2_DATA);

  // per-register increment/decrement requests; x0 never set (rd!=0, pend[0]==0)
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (accept && writes_rd) inc_v[SCHEDULE_1ST_RD] = 1'b1;
    if (WB_VALID && pend[WB_RD] != '0) dec_v[WB_RD] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      pend <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        case ({inc_v[i], dec_v[i]})
          2'b10:   pend[i] <= pend[i] + PEND_ONE;
          2'b01:   pend[i] <= pend[i] - PEND_ONE;
          default: pend[i] <= pend[i];
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH || (!MEM_WAIT && STALL)) begin
      SCHEDULE_2ND_PC       <= '0;
      SCHEDULE_2ND_OPCODE   <= '0;
      SCHEDULE_2ND_RD       <= '0;
      SCHEDULE_2ND_CSR      <= '0;
      SCHEDULE_2ND_FUNCT3   <= '0;
      SCHEDULE_2ND_FUNCT7   <= '0;
      SCHEDULE_2ND_IMM      <= '0;
      SCHEDULE_2ND_RS1_DATA <= '0;
      SCHEDULE_2ND_RS2_DATA <= '0;
    end else if (!MEM_WAIT) begin
      SCHEDULE_2ND_PC       <= SCHEDULE_1ST_PC;
      SCHEDULE_2ND_OPCODE   <= SCHEDULE_1ST_OPCODE;
      SCHEDULE_2ND_RD       <= SCHEDULE_1ST_RD;
      SCHEDULE_2ND_CSR      <= SCHEDULE_1ST_CSR;
      SCHEDULE_2ND_FUNCT3   <= SCHEDULE_1ST_FUNCT3;
      SCHEDULE_2ND_FUNCT7   <= SCHEDULE_1ST_FUNCT7;
      SCHEDULE_2ND_IMM      <= SCHEDULE_1ST_IMM;
      SCHEDULE_2ND_RS1_DATA <= op1;
      SCHEDULE_2ND_RS2_DATA <= op2;
    end
  end
endmodule
